// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised register file.
// Holds the clear-engine state encoding and the default geometry.
package regfile_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } clr_state_t;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_REGS = 4;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Sequential bulk-clear engine: sweeps R0..R[NUM_REGS-1] to zero, one per cycle.
// Also flags writes that arrive while the sweep owns the array.
//
//   state    | meaning
//   ST_IDLE  | array free for normal writes; samples clr_req each edge
//   ST_CLEAR | zeroing R[cnt] each edge; exits after R[NUM_REGS-1]
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    input  logic              we,
    output logic              clr_busy,
    output logic              wr_drop,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    clr_state_t        state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            wr_drop  <= 1'b0;
        end else begin
            wr_drop <= we && (state == ST_CLEAR);
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state    <= ST_CLEAR;
                        cnt      <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // The last register is zeroed on this same edge, so cnt never wraps.
                    if (cnt == ADDR_W'(NUM_REGS - 1)) begin
                        state    <= ST_IDLE;
                        cnt      <= '0;
                        clr_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    cnt      <= '0;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we   = (state == ST_CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with optional zero R0, write bypass,
// a sequential bulk-clear engine and an indexed debug read port.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_R0  = 0,
    parameter int BYPASS   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic [DATA_W-1:0] qa,
    output logic [DATA_W-1:0] qb,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              wr_drop,
    input  logic [ADDR_W-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_q
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wa_writable;
    logic              wr_ok;

    regfile_clr_fsm #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_clr_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .we       (we),
        .clr_busy (clr_busy),
        .wr_drop  (wr_drop),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign wa_writable = !((ZERO_R0 != 0) && (wa == '0));
    assign wr_ok       = we && !clr_busy && wa_writable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (clr_we) begin
            regs[clr_addr] <= '0;
        end else if (wr_ok) begin
            regs[wa] <= wd;
        end
    end

    function automatic logic [DATA_W-1:0] stored(input logic [ADDR_W-1:0] a);
        if ((ZERO_R0 != 0) && (a == '0)) begin
            return '0;
        end
        return regs[a];
    endfunction

    // wr_ok already excludes busy cycles and the hardwired R0, so bypass inherits both.
    assign qa    = ((BYPASS != 0) && wr_ok && (ra == wa)) ? wd : stored(ra);
    assign qb    = ((BYPASS != 0) && wr_ok && (rb == wa)) ? wd : stored(rb);
    assign dbg_q = stored(dbg_sel);

endmodule
